// File: rtl/route_compute_xy.sv
// Per-channel XY (dimension-order) route computation with one registered
// output stage per channel and a per-channel count of LOCAL deliveries.
module route_compute_xy #(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned DATA_W  = 40,
    parameter int unsigned COORD_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*COORD_W-1:0]     current_location,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*3-1:0]      dout_dir,
    output logic [NUM_CH*DATA_W-1:0] dout_data,
    output logic [NUM_CH*16-1:0]     pkt_cnt
);

    localparam int unsigned LOC_W = 2 * COORD_W;
    localparam int unsigned DIR_W = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [DIR_W-1:0] DIR_NONE  = 3'b000;
    localparam logic [DIR_W-1:0] DIR_XPOS  = 3'b001;
    localparam logic [DIR_W-1:0] DIR_XNEG  = 3'b010;
    localparam logic [DIR_W-1:0] DIR_YPOS  = 3'b011;
    localparam logic [DIR_W-1:0] DIR_YNEG  = 3'b100;
    localparam logic [DIR_W-1:0] DIR_LOCAL = 3'b101;

    // X is resolved fully before Y; equal coordinates mean the packet is home.
    function automatic logic [DIR_W-1:0] route_dir(input logic [LOC_W-1:0] dest,
                                                   input logic [LOC_W-1:0] cur);
        logic [COORD_W-1:0] dx, dy, cx, cy;
        logic [DIR_W-1:0]   dir;
        dx  = dest[LOC_W-1 -: COORD_W];
        dy  = dest[COORD_W-1:0];
        cx  = cur[LOC_W-1 -: COORD_W];
        cy  = cur[COORD_W-1:0];
        dir = DIR_NONE;
        if (dx > cx)      dir = DIR_XPOS;
        else if (dx < cx) dir = DIR_XNEG;
        else if (dy > cy) dir = DIR_YPOS;
        else if (dy < cy) dir = DIR_YNEG;
        else              dir = DIR_LOCAL;
        return dir;
    endfunction

    logic [NUM_CH*DIR_W-1:0] dir_c;
    logic [NUM_CH-1:0]       take_c;
    logic [NUM_CH-1:0]       deliver_c;

    // Handshake decode: a slot accepts when empty or draining this cycle.
    always_comb begin
        in_ready  = ~out_valid | out_ready;
        take_c    = in_valid & in_ready;
        deliver_c = out_valid & out_ready;
    end

    // Direction for each channel's incoming packet, from the destination field.
    always_comb begin
        dir_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            dir_c[i*DIR_W +: DIR_W] =
                route_dir(din[i*DATA_W + DATA_W - 1 - LOC_W -: LOC_W], current_location);
        end
    end

    // Output stage per channel: load on accept, clear valid on drain, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            dout_dir  <= '0;
            dout_data <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (take_c[i]) begin
                    out_valid[i]                <= 1'b1;
                    dout_dir[i*DIR_W +: DIR_W]  <= dir_c[i*DIR_W +: DIR_W];
                    dout_data[i*DATA_W +: DATA_W] <= din[i*DATA_W +: DATA_W];
                end else if (deliver_c[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Count packets handed downstream with a LOCAL direction; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (deliver_c[i] && (dout_dir[i*DIR_W +: DIR_W] == DIR_LOCAL)) begin
                    pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_route_compute_xy.sv
// Directed bench for route_compute_xy: default 3-channel instance plus a
// single-channel COORD_W=2 instance for multi-bit coordinate routing.
module tb_route_compute_xy;

    localparam logic [2:0] D_XPOS  = 3'b001;
    localparam logic [2:0] D_XNEG  = 3'b010;
    localparam logic [2:0] D_YPOS  = 3'b011;
    localparam logic [2:0] D_YNEG  = 3'b100;
    localparam logic [2:0] D_LOCAL = 3'b101;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   current_location;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready;
    logic [119:0] din, dout_data;
    logic [8:0]   dout_dir;
    logic [47:0]  pkt_cnt;

    logic [3:0]   cur2;
    logic [0:0]   in_valid2, in_ready2, out_valid2, out_ready2;
    logic [39:0]  din2, dout_data2;
    logic [2:0]   dout_dir2;
    logic [15:0]  pkt_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    route_compute_xy u_dut (
        .clk(clk), .rst_n(rst_n), .current_location(current_location),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_dir(dout_dir), .dout_data(dout_data), .pkt_cnt(pkt_cnt)
    );

    route_compute_xy #(.NUM_CH(1), .DATA_W(40), .COORD_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .current_location(cur2),
        .in_valid(in_valid2), .in_ready(in_ready2), .din(din2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .dout_dir(dout_dir2), .dout_data(dout_data2), .pkt_cnt(pkt_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {src, dest, payload} for the default 1-bit-coordinate layout
    function automatic logic [39:0] mk(input logic [1:0] src, input logic [1:0] dst,
                                       input logic [35:0] pl);
        return {src, dst, pl};
    endfunction

    logic [39:0] pa, pb, pc;
    logic [3:0]  dst2 [6];
    logic [2:0]  exp2 [6];

    initial begin
        rst_n = 1'b0; current_location = 2'b00; in_valid = '0; out_ready = '0; din = '0;
        cur2 = 4'b0; in_valid2 = '0; out_ready2 = '0; din2 = '0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h7);
        check("rst_dout_dir",  64'(dout_dir),  64'h0);
        check("rst_pkt_cnt",   64'(pkt_cnt),   64'h0);
        // valid asserted during reset must not be captured
        in_valid = 3'b111; din = {3{mk(2'b00, 2'b11, 36'h1)}};
        tick(); tick();
        in_valid = '0;
        rst_n = 1'b1;
        tick();
        check("rst_no_capture", 64'(out_valid), 64'h0);
        check("rst_dout_data",  64'(dout_data[39:0]), 64'h0);

        // single XPOS packet, one-cycle latency, then drain with hold
        out_ready = 3'b111;
        pa = mk(2'b00, 2'b10, 36'h123456789);
        din[39:0] = pa; in_valid = 3'b001;
        tick();
        in_valid = '0;
        check("xpos_valid", 64'(out_valid), 64'h1);
        check("xpos_dir",   64'(dout_dir[2:0]), 64'(D_XPOS));
        check("xpos_data",  64'(dout_data[39:0]), 64'(pa));
        tick();
        check("xpos_drain_valid", 64'(out_valid), 64'h0);
        check("xpos_hold_dir",    64'(dout_dir[2:0]), 64'(D_XPOS));
        check("xpos_hold_data",   64'(dout_data[39:0]), 64'(pa));

        // three channels at once from location 11
        current_location = 2'b11;
        pa = mk(2'b01, 2'b11, 36'hAAAA);
        pb = mk(2'b10, 2'b01, 36'hBBBB);
        pc = mk(2'b00, 2'b10, 36'hCCCC);
        din = {pc, pb, pa}; in_valid = 3'b111;
        tick();
        in_valid = '0;
        check("multi_valid", 64'(out_valid), 64'h7);
        check("multi_dir",   64'(dout_dir), 64'({D_YNEG, D_XNEG, D_LOCAL}));
        check("multi_data1", 64'(dout_data[79:40]), 64'(pb));
        check("multi_cnt_pre", 64'(pkt_cnt[15:0]), 64'h0);
        tick();
        check("multi_cnt0", 64'(pkt_cnt[15:0]), 64'h1);
        check("multi_cnt12", 64'(pkt_cnt[47:16]), 64'h0);
        check("multi_drained", 64'(out_valid), 64'h0);

        // backpressure on ch0: hold A for 5 cycles while B waits, then swap with no bubble
        out_ready = 3'b000;
        pa = mk(2'b00, 2'b11, 36'h0A0A);
        pb = mk(2'b00, 2'b00, 36'h0B0B);
        din[39:0] = pa; in_valid = 3'b001;
        tick();
        din[39:0] = pb;
        check("stall_in_ready", 64'(in_ready[0]), 64'h0);
        current_location = 2'b00;  // held result must not follow location changes
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_hold_data", 64'(dout_data[39:0]), 64'(pa));
            check("stall_hold_valid", 64'(out_valid[0]), 64'h1);
        end
        check("stall_hold_dir", 64'(dout_dir[2:0]), 64'(D_LOCAL));
        current_location = 2'b11;
        out_ready = 3'b001;
        #1;
        check("release_in_ready", 64'(in_ready[0]), 64'h1);
        tick();
        in_valid = '0;
        check("swap_valid", 64'(out_valid[0]), 64'h1);
        check("swap_data",  64'(dout_data[39:0]), 64'(pb));
        check("swap_dir",   64'(dout_dir[2:0]), 64'(D_XNEG));
        check("swap_cnt",   64'(pkt_cnt[15:0]), 64'h2);
        tick();
        check("swap_drain", 64'(out_valid[0]), 64'h0);
        check("swap_cnt_nonlocal", 64'(pkt_cnt[15:0]), 64'h2);

        // COORD_W=2 from {x=2,y=1}: streamed at full rate through one channel
        cur2 = {2'd2, 2'd1};
        out_ready2 = 1'b1;
        dst2[0] = {2'd2, 2'd3}; exp2[0] = D_YPOS;
        dst2[1] = {2'd3, 2'd0}; exp2[1] = D_XPOS;
        dst2[2] = {2'd1, 2'd3}; exp2[2] = D_XNEG;
        dst2[3] = {2'd2, 2'd0}; exp2[3] = D_YNEG;
        dst2[4] = {2'd2, 2'd1}; exp2[4] = D_LOCAL;
        dst2[5] = {2'd0, 2'd1}; exp2[5] = D_XNEG;
        for (int k = 0; k < 6; k++) begin
            din2 = {4'hF, dst2[k], 32'(k)};
            in_valid2 = 1'b1;
            check("c2_in_ready", 64'(in_ready2), 64'h1);
            tick();
            check("c2_dir",  64'(dout_dir2), 64'(exp2[k]));
            check("c2_data", 64'(dout_data2), 64'({4'hF, dst2[k], 32'(k)}));
        end
        in_valid2 = 1'b0;
        tick();
        check("c2_cnt", 64'(pkt_cnt2), 64'h1);

        // counter wrap: 65535 LOCAL packets back-to-back, then one more
        rst_n = 1'b0; #1; rst_n = 1'b1;
        current_location = 2'b11;
        out_ready = 3'b001;
        din[39:0] = mk(2'b00, 2'b11, 36'h5);
        in_valid = 3'b001;
        repeat (65535) tick();
        in_valid = '0;
        tick();
        check("wrap_ffff", 64'(pkt_cnt[15:0]), 64'hFFFF);
        in_valid = 3'b001;
        tick();
        in_valid = '0;
        tick();
        check("wrap_zero", 64'(pkt_cnt[15:0]), 64'h0);

        // async reset mid-stall drops the held packet with no handshake
        out_ready = 3'b000;
        in_valid = 3'b001;
        tick();
        in_valid = '0;
        check("pre_rst_valid", 64'(out_valid[0]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'h0);
        check("async_data",  64'(dout_data[39:0]), 64'h0);
        check("async_dir",   64'(dout_dir), 64'h0);
        check("async_ready", 64'(in_ready), 64'h7);
        out_ready = 3'b001;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_cnt",   64'(pkt_cnt), 64'h0);
        check("post_rst_valid", 64'(out_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
